// File: rtl/running_max_stage_pkg.sv
// Shared types for the online-softmax running-maximum stage.
//   EXPMUL_DIFF_IN_QT : signed Q4.4 score / max operand for expmul_stage
//   STAR_VECTOR_T     : V vector of Q9.17 elements; element 0 carries the
//                       constant "1" used to build the softmax denominator
//   RUNMAX_PKT_T      : scalar part of the stage's output register
//   signed_max        : two's-complement max, ties keep the first operand
package running_max_stage_pkg;

  localparam int ROW_CNT_W_DEF = 8;
  localparam int STAR_VEC_LEN  = 4;
  localparam int STAR_ELEM_W   = 26;

  typedef logic signed [7:0]             EXPMUL_DIFF_IN_QT;
  typedef logic signed [STAR_ELEM_W-1:0] STAR_ELEM_T;
  typedef STAR_ELEM_T [STAR_VEC_LEN-1:0] STAR_VECTOR_T;

  // key_idx is kept outside the packet so its width follows the
  // ROW_CNT_W parameter of the instantiating module.
  typedef struct packed {
    EXPMUL_DIFF_IN_QT s;
    EXPMUL_DIFF_IN_QT m_old;
    EXPMUL_DIFF_IN_QT m_new;
    logic             first;
    logic             last;
  } RUNMAX_PKT_T;

  function automatic EXPMUL_DIFF_IN_QT signed_max(input EXPMUL_DIFF_IN_QT a,
                                                  input EXPMUL_DIFF_IN_QT b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/running_max_stage.sv
// Running-maximum stage of the online softmax. Tracks the max of one query
// row's Q.K scores and emits (score, new max) for the V path and
// (old max, new max) for the accumulator-rescale path of expmul_stage.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   vld_in / rdy_out    : upstream handshake (s_in, v_in, last_in)
//   vld_out / rdy_in    : downstream handshake (rdy_in = both expmul ready)
//   s_out, m_new_out,
//   m_old_out, v_out    : registered operands
//   first_out, last_out : row boundary flags
//   key_idx             : 0-based key index in row, saturating
module running_max_stage
  import running_max_stage_pkg::*;
#(
  parameter int ROW_CNT_W = ROW_CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld_in,
  output logic                 rdy_out,
  input  EXPMUL_DIFF_IN_QT     s_in,
  input  STAR_VECTOR_T         v_in,
  input  logic                 last_in,
  output logic                 vld_out,
  input  logic                 rdy_in,
  output EXPMUL_DIFF_IN_QT     s_out,
  output EXPMUL_DIFF_IN_QT     m_new_out,
  output EXPMUL_DIFF_IN_QT     m_old_out,
  output STAR_VECTOR_T         v_out,
  output logic                 first_out,
  output logic                 last_out,
  output logic [ROW_CNT_W-1:0] key_idx
);

  RUNMAX_PKT_T           pkt_q, pkt_d;
  STAR_VECTOR_T          v_q, v_d;
  logic [ROW_CNT_W-1:0]  idx_q, idx_d;
  logic                  vld_out_q, vld_out_d;
  EXPMUL_DIFF_IN_QT      m_run_q, m_run_d;
  logic                  row_active_q, row_active_d;
  logic [ROW_CNT_W-1:0]  cnt_q, cnt_d;

  logic                  xfer_in;
  EXPMUL_DIFF_IN_QT      m_old_c, m_new_c;

  // Ready only looks at the output register and downstream ready, so there
  // is no combinational path from vld_in back to rdy_out.
  assign rdy_out = !vld_out_q || rdy_in;

  always_comb begin
    xfer_in      = vld_in && rdy_out;
    // First key of a row compares against itself so the rescale factor is 1.
    m_old_c      = row_active_q ? m_run_q : s_in;
    m_new_c      = row_active_q ? signed_max(m_run_q, s_in) : s_in;

    pkt_d        = pkt_q;
    v_d          = v_q;
    idx_d        = idx_q;
    vld_out_d    = vld_out_q;
    m_run_d      = m_run_q;
    row_active_d = row_active_q;
    cnt_d        = cnt_q;

    if (xfer_in) begin
      pkt_d.s     = s_in;
      pkt_d.m_old = m_old_c;
      pkt_d.m_new = m_new_c;
      pkt_d.first = !row_active_q;
      pkt_d.last  = last_in;
      v_d         = v_in;
      idx_d       = row_active_q ? cnt_q : '0;
      vld_out_d   = 1'b1;
      if (last_in) begin
        // m_run is left as is; the next key is a first and ignores it.
        row_active_d = 1'b0;
        cnt_d        = '0;
      end else begin
        row_active_d = 1'b1;
        m_run_d      = m_new_c;
        // cnt is 0 whenever the row is idle, so this also covers the first key.
        cnt_d        = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
    end else if (rdy_in) begin
      vld_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_q        <= '0;
      v_q          <= '0;
      idx_q        <= '0;
      vld_out_q    <= 1'b0;
      m_run_q      <= '0;
      row_active_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      pkt_q        <= pkt_d;
      v_q          <= v_d;
      idx_q        <= idx_d;
      vld_out_q    <= vld_out_d;
      m_run_q      <= m_run_d;
      row_active_q <= row_active_d;
      cnt_q        <= cnt_d;
    end
  end

  assign vld_out   = vld_out_q;
  assign s_out     = pkt_q.s;
  assign m_old_out = pkt_q.m_old;
  assign m_new_out = pkt_q.m_new;
  assign first_out = pkt_q.first;
  assign last_out  = pkt_q.last;
  assign v_out     = v_q;
  assign key_idx   = idx_q;

endmodule

// File: tb/tb_running_max_stage.sv
// Scoreboard bench for running_max_stage: accepted keys are run through a
// row-level reference model (max over the list of scores seen so far in
// the row) and queued; a monitor pops and compares on every output transfer.
module tb_running_max_stage;
  import running_max_stage_pkg::*;

  typedef struct {
    logic [7:0]   s;
    logic [7:0]   mo;
    logic [7:0]   mn;
    logic         first;
    logic         last;
    logic [7:0]   idx;
    STAR_VECTOR_T v;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             vld_in;
  logic             rdy_out;
  EXPMUL_DIFF_IN_QT s_in;
  STAR_VECTOR_T     v_in;
  logic             last_in;
  logic             vld_out;
  logic             rdy_in;
  EXPMUL_DIFF_IN_QT s_out;
  EXPMUL_DIFF_IN_QT m_new_out;
  EXPMUL_DIFF_IN_QT m_old_out;
  STAR_VECTOR_T     v_out;
  logic             first_out;
  logic             last_out;
  logic [7:0]       key_idx;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   row_q[$];
  logic rand_rdy = 1'b0;

  running_max_stage #(.ROW_CNT_W(8)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out),
    .s_in(s_in), .v_in(v_in), .last_in(last_in),
    .vld_out(vld_out), .rdy_in(rdy_in),
    .s_out(s_out), .m_new_out(m_new_out), .m_old_out(m_old_out),
    .v_out(v_out), .first_out(first_out), .last_out(last_out),
    .key_idx(key_idx)
  );

  always #5 clk = ~clk;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkv(input string name, input STAR_VECTOR_T act, input STAR_VECTOR_T exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the row is a list of scores; max is taken over it.
  task automatic record_accept(input logic [7:0] s, input STAR_VECTOR_T v, input logic last);
    exp_t e;
    int   mo;
    int   sv;
    sv = int'($signed(s));
    e.s = s; e.v = v; e.last = last;
    if (row_q.size() == 0) begin
      e.mo = s; e.mn = s; e.first = 1'b1;
    end else begin
      mo = row_q[0];
      foreach (row_q[i]) if (row_q[i] > mo) mo = row_q[i];
      e.mo = 8'(mo);
      e.mn = (sv > mo) ? s : 8'(mo);
      e.first = 1'b0;
    end
    e.idx = (row_q.size() > 255) ? 8'hFF : 8'(row_q.size());
    row_q.push_back(sv);
    if (last) row_q.delete();
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) rdy_in = ($urandom_range(0, 9) < 7);
  endtask

  function automatic STAR_VECTOR_T rand_vec();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[103:0];
  endfunction

  task automatic send(input logic [7:0] s, input logic last, output STAR_VECTOR_T v);
    bit acc;
    acc = 1'b0;
    v = rand_vec();
    vld_in = 1'b1; s_in = s; v_in = v; last_in = last;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (rdy_out) begin
        record_accept(s, v, last);
        acc = 1'b1;
      end
      tick();
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: key %h not accepted within 200 cycles", s);
    end
    vld_in = 1'b0;
  endtask

  // Monitor: runs shortly after the falling edge, after the driver has queued
  // any key accepted on the same cycle.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst) begin
      chk8("rdy_out_rule", 8'(rdy_out), 8'(!vld_out || rdy_in));
      if (vld_out && rdy_in) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_output: got output s=%h with empty scoreboard", s_out);
        end else begin
          e = sb.pop_front();
          chk8("s_out", s_out, e.s);
          chk8("m_old_out", m_old_out, e.mo);
          chk8("m_new_out", m_new_out, e.mn);
          chk8("first_out", 8'(first_out), 8'(e.first));
          chk8("last_out", 8'(last_out), 8'(e.last));
          chk8("key_idx", key_idx, e.idx);
          chkv("v_out", v_out, e.v);
          chk8("inv_new_ge_old", 8'($signed(m_new_out) >= $signed(m_old_out)), 8'd1);
          chk8("inv_new_ge_s", 8'($signed(m_new_out) >= $signed(s_out)), 8'd1);
        end
      end
    end
  end

  initial begin
    STAR_VECTOR_T v, va;
    logic [7:0] row1_s  [4] = '{8'h10, 8'h30, 8'h20, 8'hF0};
    logic [7:0] row1_mo [4] = '{8'h10, 8'h10, 8'h30, 8'h30};
    logic [7:0] row1_mn [4] = '{8'h10, 8'h30, 8'h30, 8'h30};

    rst = 1'b1; vld_in = 1'b0; s_in = '0; v_in = '0; last_in = 1'b0; rdy_in = 1'b1;
    repeat (3) tick();
    chk8("rst_vld_out", 8'(vld_out), 8'd0);
    chk8("rst_s_out", s_out, 8'h00);
    chk8("rst_m_new", m_new_out, 8'h00);
    chk8("rst_m_old", m_old_out, 8'h00);
    chk8("rst_key_idx", key_idx, 8'h00);
    chk8("rst_first", 8'(first_out), 8'd0);
    rst = 1'b0;
    tick();

    // Directed row 1.0, 3.0, 2.0, -1.0
    for (int i = 0; i < 4; i++) begin
      send(row1_s[i], i == 3, v);
      chk8("row1_m_old", m_old_out, row1_mo[i]);
      chk8("row1_m_new", m_new_out, row1_mn[i]);
      chk8("row1_first", 8'(first_out), 8'(i == 0));
      chk8("row1_last", 8'(last_out), 8'(i == 3));
      chk8("row1_idx", key_idx, 8'(i));
    end
    // Row 2, all negative: row 1's max must not leak
    send(8'hE0, 1'b0, v);
    chk8("row2_k0_m_old", m_old_out, 8'hE0);
    chk8("row2_k0_m_new", m_new_out, 8'hE0);
    chk8("row2_k0_first", 8'(first_out), 8'd1);
    send(8'hC0, 1'b1, v);
    chk8("row2_k1_m_new", m_new_out, 8'hE0);

    // Backpressure
    tick(); tick();
    rdy_in = 1'b0;
    send(8'h40, 1'b0, va);
    vld_in = 1'b1; s_in = 8'h20; v = rand_vec(); v_in = v; last_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk8("stall_rdy_out", 8'(rdy_out), 8'd0);
      chk8("stall_vld_out", 8'(vld_out), 8'd1);
      chk8("stall_s_out", s_out, 8'h40);
      chk8("stall_m_new", m_new_out, 8'h40);
      chkv("stall_v_out", v_out, va);
      tick();
    end
    rdy_in = 1'b1;
    @(negedge clk);
    chk8("release_rdy_out", 8'(rdy_out), 8'd1);
    if (rdy_out) record_accept(8'h20, v, 1'b0);
    tick();
    vld_in = 1'b0;
    chk8("release_s_out", s_out, 8'h20);
    chk8("release_m_old", m_old_out, 8'h40);
    chk8("release_m_new", m_new_out, 8'h40);
    send(8'h00, 1'b1, v);

    // Single-element row, then a fresh first key
    send(8'h80, 1'b1, v);
    chk8("single_m_old", m_old_out, 8'h80);
    chk8("single_m_new", m_new_out, 8'h80);
    chk8("single_first", 8'(first_out), 8'd1);
    chk8("single_last", 8'(last_out), 8'd1);
    send(8'h05, 1'b0, v);
    chk8("after_single_first", 8'(first_out), 8'd1);

    // Reset mid-row
    send(8'h50, 1'b0, v);
    send(8'h60, 1'b0, v);
    rst = 1'b1;
    tick();
    chk8("mid_rst_vld_out", 8'(vld_out), 8'd0);
    chk8("mid_rst_s_out", s_out, 8'h00);
    chk8("mid_rst_m_old", m_old_out, 8'h00);
    chk8("mid_rst_m_new", m_new_out, 8'h00);
    chk8("mid_rst_flags", {6'd0, first_out, last_out}, 8'h00);
    chk8("mid_rst_idx", key_idx, 8'h00);
    chkv("mid_rst_v_out", v_out, '0);
    rst = 1'b0;
    sb.delete();
    row_q.delete();
    tick();
    send(8'h70, 1'b0, v);
    chk8("post_rst_first", 8'(first_out), 8'd1);
    chk8("post_rst_idx", key_idx, 8'h00);
    chk8("post_rst_m_old", m_old_out, 8'h70);
    send(8'h00, 1'b1, v);

    // Long row: key index saturates at all-ones
    for (int i = 0; i < 260; i++) begin
      send(8'($urandom), i == 259, v);
    end
    chk8("sat_idx", key_idx, 8'hFF);

    // Random scores, gaps and backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send(8'($urandom), $urandom_range(0, 4) == 0, v);
    end
    rand_rdy = 1'b0;
    rdy_in = 1'b1;
    for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
    chk8("drain_empty", 8'(sb.size()), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/running_max_stage.md
# running_max_stage

Online-softmax running-maximum stage feeding `expmul_stage`. It consumes one query row's stream of Q·K scores, each paired with its V vector. For each score it tracks the row maximum and emits two operand pairs: (score, new max) to the V-path `expmul_stage`, and (old max, new max) to the accumulator-rescale `expmul_stage`. The maximum resets on the row's last element.

## Interface
Parameters:
- `ROW_CNT_W`, 8, width of the per-row key counter (saturating).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `vld_in` in 1: upstream score/vector valid.
- `rdy_out` out 1: stage can accept.
- `s_in` in `EXPMUL_DIFF_IN_QT`: signed Q4.4 score.
- `v_in` in `STAR_VECTOR_T`: Q9.17 V vector; element 0 carries the "1" used for the denominator.
- `last_in` in 1: final key of the current query row.
- `vld_out` out 1: outputs valid.
- `rdy_in` in 1: both downstream `expmul_stage` instances ready (ANDed externally).
- `s_out` out `EXPMUL_DIFF_IN_QT`: registered score, the `a` input of the V path.
- `m_new_out` out `EXPMUL_DIFF_IN_QT`: row max including this score, the `b` input of both paths.
- `m_old_out` out `EXPMUL_DIFF_IN_QT`: row max before this score, the `a` input of the rescale path.
- `v_out` out `STAR_VECTOR_T`: registered V vector.
- `first_out` out 1: first key of the row; the accumulator loads instead of adding.
- `last_out` out 1: registered `last_in`.
- `key_idx` out `ROW_CNT_W`: 0-based index of the key within the row, saturating at all-ones.

## Operation
- Internal state:
  - `m_run`: signed Q4.4 running max.
  - `row_active`: 1 after the first key of a row is accepted.
  - `cnt`: key counter.
- Transfer in: `vld_in && rdy_out`. Transfer out: `vld_out && rdy_in`.
- On transfer in:
  - If `!row_active`:
    - m_old = s_in, m_new = s_in, so the rescale factor is exp(0)=1.
    - first = 1, idx = 0.
  - Else:
    - m_old = m_run, m_new = signed max(m_run, s_in).
    - first = 0, idx = cnt.
  - Register s, v, last, m_old, m_new, first and idx into the output register.
  - If `last_in`: `row_active` ← 0, `cnt` ← 0, and `m_run` is don't-care.
  - Else: `row_active` ← 1, `m_run` ← m_new, `cnt` ← cnt+1, saturating.
- Max compare is a signed two's-complement compare. Ties keep m_run; the value is identical either way.
- A single-element row (`last_in` on the first key) gives first=1, last=1, m_old=m_new=s.
- Invariant: m_new_out ≥ m_old_out and m_new_out ≥ s_out on every valid output. This keeps the exponent ≤ 0 downstream.
- Row state updates only on transfer in; a stall never changes `m_run`.

## Timing
- Reset values: all registered outputs are 0, `vld_out`=0, `row_active`=0, `m_run`=0, `cnt`=0.
- Reset mid-row discards the partial row; the next accepted key is treated as first.
- Latency: 1 cycle from transfer in to `vld_out`.
- Handshake:
  - `rdy_out = !vld_out || rdy_in`, so full throughput is one key per cycle.
  - `vld_out` ← 1 on transfer in.
  - Otherwise `vld_out` ← 0 when `rdy_in`.
  - The output register holds stable while `vld_out && !rdy_in`.
- A simultaneous transfer out and transfer in on the same cycle replaces the output register with no bubble.
- `rdy_out` depends combinationally on `rdy_in`. There is no valid→ready path inside the block.

## Structure
- Add to `sys_defs.svh`: `ROW_CNT_W` default, and `RUNMAX_PKT_T` (a struct of s, m_old, m_new, first, last, idx) so the output register is a single typed flop.
- Reuse the existing `EXPMUL_DIFF_IN_QT` and `STAR_VECTOR_T`; introduce no new Q formats.
- No sub-module is required. A small `signed_max` function may live in the shared package.

## Test plan
- Row of scores 1.0, 3.0, 2.0, −1.0 (0x10, 0x30, 0x20, 0xF0), last on the fourth, `rdy_in`=1:
  - (m_old, m_new) = (0x10,0x10), (0x10,0x30), (0x30,0x30), (0x30,0x30).
  - first only on key 0, last only on key 3.
  - key_idx = 0..3.
- Two back-to-back rows, with row 2 scores all negative (0xE0, 0xC0): row 2 key 0 gives m_old = m_new = 0xE0 and first=1. This proves reset of the max on `last`, and that row 1's max of 0x30 does not leak.
- Backpressure: hold `rdy_in`=0 for 3 cycles while `vld_out`=1.
  - Outputs stay stable and `rdy_out`=0.
  - `m_run` is unchanged.
  - Release: next key is accepted the same cycle.
- Single-element row: s=0x80 (−8.0) with `last_in`=1 gives m_old = m_new = 0x80, first = last = 1. The following key is again first.
- Assert `rst` after 2 keys of a row:
  - all outputs return to 0 and `vld_out`=0.
  - next key gives first=1, key_idx=0.
- Random scores and random `rdy_in`: scoreboard checks the m_new ≥ m_old and m_new ≥ s invariants, in-order lossless delivery of v_out, and m_new equal to the prefix max computed by a reference model.
